// File: rtl/p_ram_io_master.sv
// P_RAM initiator: converts burst requests into single-word startIO accesses,
// streaming write data in and read data out over valid/ready handshakes.
module p_ram_io_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int ADDR_STRIDE  = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // Burst request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    // Write stream
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    // Read stream
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    // Status
    output logic                  busy,
    output logic                  done,
    // P_RAM port
    output logic                  mem_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    // Debug view of the FSM state
    output logic [2:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits for ready, and ready in WRITE simply
    // mirrors wdata_valid because every offered word goes straight to P_RAM.

    localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [LEN_WIDTH-1:0]    count_q;
    logic [LEN_WIDTH-1:0]    count_d;
    logic [LAT_W-1:0]        lat_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rdata_valid_q;

    logic slot_free;
    logic wr_fire;
    logic rd_issue;
    logic rd_capture;
    logic rd_take;
    logic last_word;

    always_comb begin
        // The read slot can take a new word if empty or emptied this cycle.
        slot_free  = !rdata_valid_q || rdata_ready;
        wr_fire    = (state_q == S_WRITE) && wdata_valid;
        rd_issue   = (state_q == S_RD_ISSUE) && slot_free;
        rd_capture = (state_q == S_RD_WAIT) && (lat_q == LAT_W'(1));
        rd_take    = rdata_valid_q && rdata_ready;
        last_word  = (count_q == LEN_WIDTH'(1));
        addr_d     = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
        count_d    = count_q - LEN_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            lat_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            // A reload in the same cycle as a handshake keeps the slot full.
            if (rd_capture) begin
                rdata_q       <= mem_rd;
                rdata_valid_q <= 1'b1;
            end else if (rd_take) begin
                rdata_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        count_q <= req_len;
                        if (req_len == '0) begin
                            state_q <= S_DONE;
                        end else if (req_we) begin
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_RD_ISSUE;
                        end
                    end
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        if (last_word) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    // Holding here with the slot full is the issue-pending case.
                    if (slot_free) begin
                        lat_q   <= LAT_W'(READ_LATENCY);
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_capture) begin
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        state_q <= last_word ? S_RD_DRAIN : S_RD_ISSUE;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                S_RD_DRAIN: begin
                    if (slot_free) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign wdata_ready = wr_fire;
    assign mem_start   = wr_fire || rd_issue;
    assign mem_we      = wr_fire;
    assign mem_addr    = addr_q;
    assign mem_wd      = (state_q == S_WRITE) ? wdata : '0;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign dbg_state   = state_q;

endmodule
